// File: rtl/fetch_if_id_stage.sv
// Instruction fetch stage with the IF/ID pipeline register. It owns the PC and handles
// stall, branch redirect/flush, HALT, and a sticky watchdog for over-long stalls.
module fetch_if_id_stage #(
  parameter int          PC_W      = 8,
  parameter logic [3:0]  HALT_OP   = 4'hF,
  parameter int          MAX_STALL = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stallPC,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_target,
  input  logic [15:0]     imem_data,
  output logic [PC_W-1:0] imem_addr,
  output logic [15:0]     IF_ID_instr,
  output logic [PC_W-1:0] IF_ID_pc1,
  output logic            IF_ID_valid,
  output logic [3:0]      IF_ID_rd,
  output logic [3:0]      IF_ID_rs,
  output logic [3:0]      IF_ID_rt,
  output logic            halted,
  output logic            stall_err
);

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HALT = 1'b1;
  localparam logic [7:0] STALL_LIM = 8'(MAX_STALL);

  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     instr_q, instr_d;
  logic [PC_W-1:0] pc1_q, pc1_d;
  logic            valid_q, valid_d;
  logic [0:0]      state_q, state_d;
  logic [7:0]      stall_cnt_q, stall_cnt_d;
  logic            err_q, err_d;
  logic            stall_app;
  logic [PC_W-1:0] pc_inc;

  assign pc_inc    = pc_q + 1'b1;
  assign stall_app = (state_q == ST_RUN) && stallPC && !branch_taken;

  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    pc1_d   = pc1_q;
    valid_d = valid_q;
    state_d = state_q;
    if (branch_taken) begin
      pc_d    = branch_target;
      instr_d = 16'h0000;
      valid_d = 1'b0;
      state_d = ST_RUN;
    end else if (state_q == ST_HALT) begin
      instr_d = 16'h0000;
      valid_d = 1'b0;
    end else if (!stallPC) begin
      instr_d = imem_data;
      pc1_d   = pc_inc;
      valid_d = 1'b1;
      // A HALT instruction is still delivered to decode; only the PC freezes.
      if (imem_data[15:12] == HALT_OP) begin
        state_d = ST_HALT;
      end else begin
        pc_d = pc_inc;
      end
    end
  end

  always_comb begin
    stall_cnt_d = 8'd0;
    err_d       = err_q;
    if (stall_app) begin
      stall_cnt_d = (stall_cnt_q == STALL_LIM) ? stall_cnt_q : stall_cnt_q + 8'd1;
      if (stall_cnt_q == STALL_LIM) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= '0;
      instr_q     <= 16'h0000;
      pc1_q       <= '0;
      valid_q     <= 1'b0;
      state_q     <= ST_RUN;
      stall_cnt_q <= 8'd0;
      err_q       <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      pc1_q       <= pc1_d;
      valid_q     <= valid_d;
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      err_q       <= err_d;
    end
  end

  assign imem_addr   = pc_q;
  assign IF_ID_instr = instr_q;
  assign IF_ID_pc1   = pc1_q;
  assign IF_ID_valid = valid_q;
  assign IF_ID_rd    = instr_q[11:8];
  assign IF_ID_rs    = instr_q[7:4];
  assign IF_ID_rt    = instr_q[3:0];
  assign halted      = (state_q == ST_HALT);
  assign stall_err   = err_q;

endmodule

// File: tb/tb_fetch_if_id_stage.sv
// Directed vector bench for fetch_if_id_stage: table-driven fetch/stall/branch/halt/wrap
// rows followed by hand sequences for the stall watchdog and reset overrides.
module tb_fetch_if_id_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallPC;
  logic        branch_taken;
  logic [7:0]  branch_target;
  logic [15:0] imem_data;
  logic [7:0]  imem_addr;
  logic [15:0] IF_ID_instr;
  logic [7:0]  IF_ID_pc1;
  logic        IF_ID_valid;
  logic [3:0]  IF_ID_rd, IF_ID_rs, IF_ID_rt;
  logic        halted;
  logic        stall_err;

  logic [15:0] imem [0:255];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;
  assign imem_data = imem[imem_addr];

  fetch_if_id_stage #(.PC_W(8), .HALT_OP(4'hF), .MAX_STALL(15)) dut (
    .clk(clk), .rst(rst), .stallPC(stallPC), .branch_taken(branch_taken),
    .branch_target(branch_target), .imem_data(imem_data), .imem_addr(imem_addr),
    .IF_ID_instr(IF_ID_instr), .IF_ID_pc1(IF_ID_pc1), .IF_ID_valid(IF_ID_valid),
    .IF_ID_rd(IF_ID_rd), .IF_ID_rs(IF_ID_rs), .IF_ID_rt(IF_ID_rt),
    .halted(halted), .stall_err(stall_err)
  );

  typedef struct {
    logic        stall;
    logic        br;
    logic [7:0]  tgt;
    logic [7:0]  e_addr;
    logic [15:0] e_instr;
    logic [7:0]  e_pc1;
    logic        chk_pc1;
    logic        e_valid;
    logic        e_halted;
  } vec_t;

  vec_t vecs [17];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step(input logic s, input logic b, input logic [7:0] t, input logic r);
    @(negedge clk);
    stallPC = s; branch_taken = b; branch_target = t; rst = r;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string nm, input logic [7:0] addr, input logic [15:0] instr,
                         input logic [7:0] pc1, input logic cp1, input logic v,
                         input logic h, input logic e);
    chk({nm, ".addr"}, 32'(imem_addr), 32'(addr));
    chk({nm, ".instr"}, 32'(IF_ID_instr), 32'(instr));
    if (cp1) chk({nm, ".pc1"}, 32'(IF_ID_pc1), 32'(pc1));
    chk({nm, ".valid"}, 32'(IF_ID_valid), 32'(v));
    chk({nm, ".rd"}, 32'(IF_ID_rd), 32'(instr[11:8]));
    chk({nm, ".rs"}, 32'(IF_ID_rs), 32'(instr[7:4]));
    chk({nm, ".rt"}, 32'(IF_ID_rt), 32'(instr[3:0]));
    chk({nm, ".halted"}, 32'(halted), 32'(h));
    chk({nm, ".err"}, 32'(stall_err), 32'(e));
  endtask

  initial begin
    for (int i = 0; i < 256; i++) imem[i] = 16'h0000;
    imem[0] = 16'h1234; imem[1] = 16'h2345; imem[2] = 16'h3456; imem[3] = 16'h4567;
    imem[4] = 16'h5678; imem[5] = 16'hF000; imem[6] = 16'h6789;
    imem[8'h40] = 16'hABCD; imem[8'h41] = 16'hBCDE; imem[8'hFF] = 16'h7001;

    //            stall br tgt    addr   instr     pc1   cp1 v  h
    vecs[0]  = '{1'b0, 1'b0, 8'h00, 8'h01, 16'h1234, 8'h01, 1'b1, 1'b1, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 8'h00, 8'h02, 16'h2345, 8'h02, 1'b1, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 8'h00, 8'h02, 16'h2345, 8'h02, 1'b1, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 8'h00, 8'h02, 16'h2345, 8'h02, 1'b1, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 8'h00, 8'h03, 16'h3456, 8'h03, 1'b1, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 8'h00, 8'h04, 16'h4567, 8'h04, 1'b1, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 8'h00, 8'h05, 16'h5678, 8'h05, 1'b1, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 8'h00, 8'h05, 16'hF000, 8'h06, 1'b1, 1'b1, 1'b1};
    vecs[8]  = '{1'b1, 1'b0, 8'h00, 8'h05, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{1'b0, 1'b0, 8'h00, 8'h05, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 1'b1, 8'h00, 8'h00, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 8'h00, 8'h01, 16'h1234, 8'h01, 1'b1, 1'b1, 1'b0};
    vecs[12] = '{1'b1, 1'b1, 8'h40, 8'h40, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 8'h00, 8'h41, 16'hABCD, 8'h41, 1'b1, 1'b1, 1'b0};
    vecs[14] = '{1'b0, 1'b1, 8'hFF, 8'hFF, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[15] = '{1'b0, 1'b0, 8'h00, 8'h00, 16'h7001, 8'h00, 1'b1, 1'b1, 1'b0};
    vecs[16] = '{1'b0, 1'b0, 8'h00, 8'h01, 16'h1234, 8'h01, 1'b1, 1'b1, 1'b0};

    stallPC = 1'b0; branch_taken = 1'b0; branch_target = 8'h00; rst = 1'b1;
    step(1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b1, 1'b1, 8'h33, 1'b1);
    chk_all("reset", 8'h00, 16'h0000, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 17; i++) begin
      step(vecs[i].stall, vecs[i].br, vecs[i].tgt, 1'b0);
      chk_all($sformatf("vec%0d", i), vecs[i].e_addr, vecs[i].e_instr, vecs[i].e_pc1,
              vecs[i].chk_pc1, vecs[i].e_valid, vecs[i].e_halted, 1'b0);
    end

    // Watchdog counter must clear when the stall is released.
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    chk_all("wd_gap", 8'h02, 16'h2345, 8'h02, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 8'h00, 1'b0);
    chk_all("wd_10b", 8'h02, 16'h2345, 8'h02, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    chk_all("wd_rel", 8'h03, 16'h3456, 8'h03, 1'b1, 1'b1, 1'b0, 1'b0);

    for (int i = 0; i < 15; i++) step(1'b1, 1'b0, 8'h00, 1'b0);
    chk_all("wd_15", 8'h03, 16'h3456, 8'h03, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    chk_all("wd_16", 8'h03, 16'h3456, 8'h03, 1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    chk_all("wd_sticky", 8'h04, 16'h4567, 8'h04, 1'b1, 1'b1, 1'b0, 1'b1);

    step(1'b1, 1'b0, 8'h00, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b1);
    chk_all("rst_midstall", 8'h00, 16'h0000, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    chk_all("post_rst", 8'h01, 16'h1234, 8'h01, 1'b1, 1'b1, 1'b0, 1'b0);

    // Reset must also leave HALT.
    step(1'b0, 1'b1, 8'h05, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    chk_all("halt2", 8'h05, 16'hF000, 8'h06, 1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    chk_all("rst_halt", 8'h00, 16'h0000, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
